// File: rtl/fp_mul_exp_normalize.sv
// fp_mul_exp_normalize: exponent normalise / unbias / range check stage of the
// single-precision floating-point multiplier. It sits after the exponent prefix
// adder and packs an IEEE-754 result behind a 2-stage valid/ready pipeline.
// Optional feature macro: FPM_ROUND_NEAREST_EN selects round-to-nearest-even.
// Without it the fraction is truncated.
module fp_mul_exp_normalize #(
    parameter int BIAS    = 127,
    parameter int EXP_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  exp_sum,
    input  logic        exp_cout,
    input  logic [47:0] mant_prod,
    input  logic        sign_in,
    input  logic        zero_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    logic               s1_valid;
    logic               s2_valid;
    logic               s1_advance;
    logic               s2_advance;

    logic               s1_sign;
    logic               s1_zero;
    logic [22:0]        s1_frac;
    logic signed [9:0]  s1_eunb;

    logic               norm;
    logic [22:0]        frac_d;
    logic signed [9:0]  eunb_d;

    logic               round_inc;
    logic [23:0]        frac_sum;
    logic signed [9:0]  eunb_r;
    logic [31:0]        result_d;
    logic               overflow_d;
    logic               underflow_d;

`ifdef FPM_ROUND_NEAREST_EN
    logic               guard_d;
    logic               sticky_d;
    logic               s1_guard;
    logic               s1_sticky;
`else
    logic               unused_low_bits;
    assign unused_low_bits = ^mant_prod[22:0];
`endif

    // A stage moves when it is empty or the stage after it is moving.
    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;
    assign out_valid  = s2_valid;

    // Select the fraction window from the product and remove the exponent bias.
    always_comb begin
        norm   = mant_prod[47];
        frac_d = norm ? mant_prod[46:24] : mant_prod[45:23];
        eunb_d = $signed({1'b0, exp_cout, exp_sum}) + $signed({9'd0, norm})
                 - $signed(10'(BIAS));
`ifdef FPM_ROUND_NEAREST_EN
        guard_d  = norm ? mant_prod[23] : mant_prod[22];
        sticky_d = norm ? (|mant_prod[22:0]) : (|mant_prod[21:0]);
`endif
    end

    // Stage 1 register: normalised fraction, unbiased exponent and side bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_frac   <= '0;
            s1_eunb   <= '0;
`ifdef FPM_ROUND_NEAREST_EN
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
`endif
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= sign_in;
                s1_zero   <= zero_in;
                s1_frac   <= frac_d;
                s1_eunb   <= eunb_d;
`ifdef FPM_ROUND_NEAREST_EN
                s1_guard  <= guard_d;
                s1_sticky <= sticky_d;
`endif
            end
        end
    end

    // Round, fold any fraction carry into the exponent, then range check and pack.
    always_comb begin
        round_inc = 1'b0;
`ifdef FPM_ROUND_NEAREST_EN
        round_inc = s1_guard & (s1_sticky | s1_frac[0]);
`endif
        frac_sum    = {1'b0, s1_frac} + {23'd0, round_inc};
        eunb_r      = s1_eunb + $signed({9'd0, frac_sum[23]});
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (s1_zero) begin
            result_d = {s1_sign, 31'd0};
        end else if (eunb_r >= $signed(10'(EXP_MAX))) begin
            result_d   = {s1_sign, 8'hFF, 23'd0};
            overflow_d = 1'b1;
        end else if (eunb_r <= 10'sd0) begin
            result_d    = {s1_sign, 31'd0};
            underflow_d = 1'b1;
        end else begin
            result_d = {s1_sign, eunb_r[7:0], frac_sum[22:0]};
        end
    end

    // Stage 2 register: holds the packed result steady while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result    <= result_d;
                overflow  <= overflow_d;
                underflow <= underflow_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_exp_normalize.sv
// Self-checking bench for fp_mul_exp_normalize: directed vector table, backpressure
// and mid-operation reset sequences, then randomized traffic against a reference model.
// Honours FPM_ROUND_NEAREST_EN the same way the design does.
module tb_fp_mul_exp_normalize;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_sum;
    logic        exp_cout;
    logic [47:0] mant_prod;
    logic        sign_in;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic [7:0]  es;
        logic        ec;
        logic [47:0] mp;
        logic        s;
        logic        z;
        logic [31:0] res;
        logic        ov;
        logic        uf;
    } vec_t;

    vec_t        vecs[14];
    logic [33:0] scoreboard[$];

    typedef struct {
        logic [7:0]  es;
        logic        ec;
        logic [47:0] mp;
        logic        s;
        logic        z;
    } beat_t;

    beat_t       bp[4];
    logic [33:0] bpExp[4];

    always #5 clk = ~clk;

    fp_mul_exp_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_sum   (exp_sum),
        .exp_cout  (exp_cout),
        .mant_prod (mant_prod),
        .sign_in   (sign_in),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference: treat the product as an integer, keep the top fraction bits,
    // and round by comparing the discarded remainder with one half ulp.
    function automatic logic [33:0] refModel(input logic [7:0] es, input logic ec,
                                             input logic [47:0] mp, input logic s,
                                             input logic z);
        longint unsigned m     = {16'd0, mp};
        int              shift = mp[47] ? 24 : 23;
        longint unsigned frac  = (m >> shift) % (64'd1 << 23);
        int              e     = int'({ec, es}) + (mp[47] ? 1 : 0) - 127;
`ifdef FPM_ROUND_NEAREST_EN
        longint unsigned rem   = m % (64'd1 << shift);
        longint unsigned half  = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && (frac % 2) == 1)) begin
            frac = frac + 1;
            if (frac == (64'd1 << 23)) begin
                frac = 0;
                e    = e + 1;
            end
        end
`endif
        if (z)        return {2'b00, s, 31'd0};
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], frac[22:0]};
    endfunction

    task automatic applyStimulus(input logic [7:0] es, input logic ec, input logic [47:0] mp,
                                 input logic s, input logic z, input logic v);
        exp_sum   = es;
        exp_cout  = ec;
        mant_prod = mp;
        sign_in   = s;
        zero_in   = z;
        in_valid  = v;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic randBeat(output beat_t b);
        logic [63:0] r;
        logic [8:0]  e9;
        r    = {$urandom, $urandom};
        b.mp = r[47:0];
        if (!b.mp[47]) b.mp[46] = 1'b1;
        if ($urandom_range(3) == 0) b.mp[21:0] = '0;
        if ($urandom_range(7) == 0) b.mp[22:0] = 23'h400000;
        e9   = ($urandom_range(1) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(400, 100));
        b.es = e9[7:0];
        b.ec = e9[8];
        b.s  = 1'($urandom_range(1));
        b.z  = ($urandom_range(7) == 0);
    endtask

    initial begin
        int    lat;
        int    sent;
        int    got;
        int    firstPop;
        int    lastPop;
        int    stale;
        beat_t b;
        logic [33:0] expv;

        vecs[0]  = '{8'hFE, 1'b0, 48'h900000000000, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0};
        vecs[1]  = '{8'hFE, 1'b0, 48'h400000000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        vecs[2]  = '{8'hFC, 1'b1, 48'h400000000000, 1'b1, 1'b0, 32'hFF800000, 1'b1, 1'b0};
        vecs[3]  = '{8'h02, 1'b0, 48'h400000000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[4]  = '{8'hFE, 1'b0, 48'h400000000000, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0};
`ifdef FPM_ROUND_NEAREST_EN
        vecs[5]  = '{8'hFE, 1'b0, 48'h400000C00000, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0};
        vecs[6]  = '{8'hFE, 1'b0, 48'h7FFFFFC00000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
`else
        vecs[5]  = '{8'hFE, 1'b0, 48'h400000C00000, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
        vecs[6]  = '{8'hFE, 1'b0, 48'h7FFFFFC00000, 1'b0, 1'b0, 32'h3FFFFFFF, 1'b0, 1'b0};
`endif
        vecs[7]  = '{8'h7D, 1'b1, 48'h400000000000, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0};
        vecs[8]  = '{8'h7E, 1'b1, 48'h400000000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[9]  = '{8'h80, 1'b0, 48'h400000000000, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0};
        vecs[10] = '{8'h7F, 1'b0, 48'h400000000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[11] = '{8'h7D, 1'b1, 48'h800000000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[12] = '{8'hFC, 1'b1, 48'h400000000000, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{8'hFE, 1'b0, 48'h400000400000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};

        // Reset
        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'd0, 1'b0, 48'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {overflow, underflow}, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Directed vectors, one beat at a time
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].es, vecs[i].ec, vecs[i].mp, vecs[i].s, vecs[i].z, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                #1;
                lat++;
            end
            checkOutput($sformatf("vec%0d_latency", i), lat, 2);
            checkOutput($sformatf("vec%0d_result", i), result, vecs[i].res);
            checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].ov);
            checkOutput($sformatf("vec%0d_underflow", i), underflow, vecs[i].uf);
        end

        // Backpressure: fill with out_ready low, hold, then drain in order
        for (int i = 0; i < 4; i++) begin
            randBeat(b);
            b.z      = 1'b0;
            bp[i]    = b;
            bpExp[i] = refModel(b.es, b.ec, b.mp, b.s, b.z);
        end
        @(negedge clk);
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            applyStimulus(bp[sent].es, bp[sent].ec, bp[sent].mp, bp[sent].s, bp[sent].z, 1'b1);
            #1;
            if (in_ready) sent++;
            else break;
        end
        checkOutput("bp_accepted", sent, 2);
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_first_result", {overflow, underflow, result}, bpExp[0]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_result", {overflow, underflow, result}, bpExp[0]);
            checkOutput("bp_hold_in_ready", in_ready, 0);
        end
        got      = 0;
        firstPop = -1;
        lastPop  = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 4 && sent >= 2)
                applyStimulus(bp[sent].es, bp[sent].ec, bp[sent].mp, bp[sent].s, bp[sent].z, 1'b1);
            else
                in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp_pop%0d", got), {overflow, underflow, result}, bpExp[got]);
                if (firstPop < 0) firstPop = c;
                lastPop = c;
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        checkOutput("bp_pop_count", got, 4);
        checkOutput("bp_pop_span", lastPop - firstPop, 3);

        // Reset while full: nothing stale may come out afterwards
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(vecs[0].es, vecs[0].ec, vecs[0].mp, vecs[0].s, vecs[0].z, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_full_out_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_result", result, 0);
        checkOutput("rst_mid_flags", {overflow, underflow}, 0);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("rst_no_stale", stale, 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            randBeat(b);
            applyStimulus(b.es, b.ec, b.mp, b.s, b.z, ($urandom_range(3) != 0));
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("rand_unexpected_beat", 1, 0);
                end else begin
                    expv = scoreboard.pop_front();
                    checkOutput("rand_beat", {overflow, underflow, result}, expv);
                end
            end
            if (in_valid && in_ready)
                scoreboard.push_back(refModel(b.es, b.ec, b.mp, b.s, b.z));
        end
        for (int c = 0; c < 10 && scoreboard.size() > 0; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                expv = scoreboard.pop_front();
                checkOutput("drain_beat", {overflow, underflow, result}, expv);
            end
        end
        checkOutput("drain_empty", scoreboard.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
